cache_bus_arbiter: RTL

//  Shares one line-burst bus port between the I$ and D$ cache controllers. Arbitrates their

---
 rtl/cache_bus_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/cache_bus_arbiter.sv
// Arbitrates the I$ and D$ line-burst requests onto one bus port and counts beats for the winner.
// Optional CACHE_ARB_ROUND_ROBIN_EN: alternating priority after each Ack (default: D$ fixed priority).
module cache_bus_arbiter #(
  parameter int PA_BITS      = 34,
  parameter int BEATSPERLINE = 8,
  parameter int LOGBWPL      = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         IFCacheBusRW,
  input  logic [PA_BITS-1:0] IFCacheBusAdr,
  input  logic [1:0]         DCacheBusRW,
  input  logic [PA_BITS-1:0] DCacheBusAdr,
  output logic               IFCacheBusAck,
  output logic               DCacheBusAck,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic [1:0]         BusRW,
  output logic [PA_BITS-1:0] BusAdr,
  input  logic               BusBeatDone,
  output logic               BusOwner,
  output logic               ArbBusy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arbState_t;

  localparam logic [LOGBWPL-1:0] LastBeat = LOGBWPL'(BEATSPERLINE - 1);

  arbState_t          state, nextState;
  logic               owner;
  logic [1:0]         rwQ;
  logic [PA_BITS-1:0] adrQ;
  logic [LOGBWPL-1:0] beatCount;

  logic ifReq, dReq, grantD, ownerLive, lastBeat, abortReq, startBurst;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic prioD;
`endif

  always_comb begin
    ifReq     = |IFCacheBusRW;
    dReq      = |DCacheBusRW;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    grantD    = dReq && (!ifReq || prioD);
`else
    grantD    = dReq;
`endif
    startBurst = (state == IDLE) && (ifReq || dReq);
    ownerLive  = owner ? dReq : ifReq;
    lastBeat   = (state == BUSY) && BusBeatDone && (beatCount == LastBeat);
    // Withdrawal only counts before the bus has committed a beat.
    abortReq   = (state == BUSY) && !ownerLive && (beatCount == '0) && !BusBeatDone;

    nextState = state;
    case (state)
      IDLE:    if (startBurst) nextState = BUSY;
      BUSY:    if (lastBeat) nextState = DONE;
               else if (abortReq) nextState = IDLE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      rwQ       <= '0;
      adrQ      <= '0;
      beatCount <= '0;
    end else begin
      state <= nextState;
      if (startBurst) begin
        owner <= grantD;
        // Illegal encodings collapse to a fetch: bit 1 wins.
        if (grantD) rwQ <= DCacheBusRW[1] ? 2'b10 : 2'b01;
        else        rwQ <= 2'b10;
        adrQ  <= grantD ? DCacheBusAdr : IFCacheBusAdr;
      end
      if ((state == BUSY) && BusBeatDone)
        beatCount <= lastBeat ? '0 : beatCount + LOGBWPL'(1);
    end
  end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      prioD <= 1'b1;
    else if (lastBeat) prioD <= ~owner;
  end
`endif

  always_comb begin
    ArbBusy       = (state == BUSY);
    BusRW         = (state == BUSY) ? rwQ : '0;
    BusAdr        = adrQ;
    BusOwner      = owner;
    BeatCount     = beatCount;
    IFCacheBusAck = lastBeat && !owner;
    DCacheBusAck  = lastBeat && owner;
  end

  ifLegal: assert property (@(posedge clk) disable iff (!reset_n) !IFCacheBusRW[0]);
  dLegal:  assert property (@(posedge clk) disable iff (!reset_n) DCacheBusRW != 2'b11);

endmodule
